// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
// Optional build feature: SYNC_FIFO_FWFT_EN (first-word fall-through read port),
// consumed by sync_fifo_param.
package fifo_pkg;

    localparam int FIFO_DW_DEFAULT    = 140;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Width needed to represent an occupancy of 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && is_pow2(depth);
    endfunction

    function automatic bit afull_ok(input int th, input int depth);
        return (th >= 1) && (th <= depth);
    endfunction

    function automatic bit aempty_ok(input int th, input int depth);
        return (th >= 0) && (th <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW storage array: one synchronous write port, one asynchronous read
// port. Contents are not reset; the pointers in the top level decide validity.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DW    = FIFO_DW_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Store the accepted write word.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
// Build option: define SYNC_FIFO_FWFT_EN for a first-word fall-through read
// port; otherwise data_from_fifo is registered and loads on an accepted read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DW        = FIFO_DW_DEFAULT,
    parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int LW        = level_w(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          fifo_clear,
    input  logic          fifo_w_enable,
    input  logic [DW-1:0] data_to_fifo,
    input  logic          fifo_r_enable,
    output logic [DW-1:0] data_from_fifo,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          fifo_almost_full,
    output logic          fifo_almost_empty,
    output logic [LW-1:0] fifo_level,
    output logic          fifo_overflow,
    output logic          fifo_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] AFULL_LV  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_LV = LW'(AEMPTY_TH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
    end
    if (!afull_ok(AFULL_TH, DEPTH)) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must be within 1..DEPTH");
    end
    if (!aempty_ok(AEMPTY_TH, DEPTH)) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must be within 0..DEPTH-1");
    end

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] mem_rdata;

    // Pointer-derived full/empty: the wrap bit distinguishes full from empty.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign fifo_level        = level_q;
    assign fifo_almost_full  = (level_q >= AFULL_LV);
    assign fifo_almost_empty = (level_q <= AEMPTY_LV);
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = udf_q;

    // Flush wins over both enables; flags come from the pre-edge state.
    assign wr_acc = fifo_w_enable && !fifo_full  && !fifo_clear;
    assign rd_acc = fifo_r_enable && !fifo_empty && !fifo_clear;

    fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_in (clk_in),
        .we     (wr_acc),
        .waddr  (wptr_q[AW-1:0]),
        .wdata  (data_to_fifo),
        .raddr  (rptr_q[AW-1:0]),
        .rdata  (mem_rdata)
    );

    // Next-state for pointers, occupancy and the sticky error bits.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (fifo_clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PTR_ONE;
            if (rd_acc) rptr_d = rptr_q + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (fifo_w_enable && fifo_full)  ovf_d = 1'b1;
            if (fifo_r_enable && fifo_empty) udf_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry falls through combinationally; forced to zero when empty.
    always_comb begin
        data_from_fifo = '0;
        if (!fifo_empty) data_from_fifo = mem_rdata;
    end
`else
    logic [DW-1:0] dout_q, dout_d;

    // Output register loads the head entry only on an accepted read.
    always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_rdata;
    end

    // Registered read data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_from_fifo = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based model.
// Build with or without SYNC_FIFO_FWFT_EN; read-data expectations follow the build.
module tb_sync_fifo_param;

    localparam int DW        = 140;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = DEPTH - 1;
    localparam int AEMPTY_TH = 1;
    localparam int LW        = $clog2(DEPTH + 1);

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          fifo_clear;
    logic          fifo_w_enable;
    logic [DW-1:0] data_to_fifo;
    logic          fifo_r_enable;
    logic [DW-1:0] data_from_fifo;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic [LW-1:0] fifo_level;
    logic          fifo_overflow;
    logic          fifo_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_udf;
    int            n_writes;

    always #5 clk_in = ~clk_in;

    sync_fifo_param #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk_in            (clk_in),
        .rst_n             (rst_n),
        .fifo_clear        (fifo_clear),
        .fifo_w_enable     (fifo_w_enable),
        .data_to_fifo      (data_to_fifo),
        .fifo_r_enable     (fifo_r_enable),
        .data_from_fifo    (data_from_fifo),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_level        (fifo_level),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] w(input int v);
        return DW'(v);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // One clock of the model, evaluated from the state before the edge.
    task automatic model_step(input logic we, input logic re, input logic clr,
                              input logic [DW-1:0] d);
        logic          was_full, was_empty;
        logic [DW-1:0] popped;
        popped = '0;
        if (clr) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (we && was_full)  exp_ovf = 1'b1;
            if (re && was_empty) exp_udf = 1'b1;
            if (re && !was_empty) begin
                popped = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                exp_dout = popped;
`endif
            end
            if (we && !was_full) begin
                q.push_back(d);
                n_writes++;
            end
        end
`ifdef SYNC_FIFO_FWFT_EN
        exp_dout = (q.size() != 0) ? q[0] : '0;
`endif
    endtask

    task automatic do_cycle(input logic we, input logic [DW-1:0] d,
                            input logic re, input logic clr);
        @(negedge clk_in);
        fifo_w_enable = we;
        data_to_fifo  = d;
        fifo_r_enable = re;
        fifo_clear    = clr;
        @(posedge clk_in);
        model_step(we, re, clr, d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_clear = 1'b0; fifo_w_enable = 1'b0; fifo_r_enable = 1'b0;
        data_to_fifo = '0;
        model_reset();
        #12;
        n_checks += 8;
        if (data_from_fifo !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", data_from_fifo); end
        if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", fifo_full); end
        if (fifo_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", fifo_almost_empty); end
        if (fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", fifo_almost_full); end
        if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", fifo_overflow); end
        if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf got %b want 0", fifo_underflow); end
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1'b1, w(i), 1'b0, 1'b0);
            n_checks += 5;
            if (fifo_level !== LW'(i)) begin n_fail++; $display("FAIL fill_level got %0d want %0d", fifo_level, i); end
            if (fifo_almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_afull lvl %0d got %b", i, fifo_almost_full); end
            if (fifo_full !== (i == 4)) begin n_fail++; $display("FAIL fill_full lvl %0d got %b", i, fifo_full); end
            if (fifo_almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_aempty lvl %0d got %b", i, fifo_almost_empty); end
            if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty lvl %0d got %b want 0", i, fifo_empty); end
        end
`ifdef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (data_from_fifo !== w(1)) begin n_fail++; $display("FAIL fill_fwft_head got %h want 1", data_from_fifo); end
`endif
    endtask

    task automatic test_overflow();
        logic [DW-1:0] want;
        do_cycle(1'b1, w(5), 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        want = w(2);
`else
        want = w(1);
`endif
        n_checks += 3;
        if (data_from_fifo !== want) begin n_fail++; $display("FAIL ovf_read got %h want %h", data_from_fifo, want); end
        if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL ovf_level got %0d want 3", fifo_level); end
        if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", fifo_overflow); end
        do_cycle(1'b0, '0, 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", fifo_overflow); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] want;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (data_from_fifo !== exp_dout) begin n_fail++; $display("FAIL drain_data got %h want %h", data_from_fifo, exp_dout); end
        end
        n_checks += 2;
        if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", fifo_empty); end
        if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf got %b want 0", fifo_underflow); end
        do_cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        want = '0;
`else
        want = w(4);
`endif
        n_checks += 3;
        if (fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag got %b want 1", fifo_underflow); end
        if (fifo_level !== '0) begin n_fail++; $display("FAIL udf_level got %0d want 0", fifo_level); end
        if (data_from_fifo !== want) begin n_fail++; $display("FAIL udf_dout got %h want %h", data_from_fifo, want); end
    endtask

    task automatic test_clear();
        do_cycle(1'b1, w(32'hA1), 1'b0, 1'b0);
        do_cycle(1'b1, w(32'hA2), 1'b0, 1'b0);
        n_checks++;
        if (fifo_level !== LW'(2)) begin n_fail++; $display("FAIL clr_pre_level got %0d want 2", fifo_level); end
        do_cycle(1'b1, w(32'hA3), 1'b0, 1'b1);
        n_checks += 4;
        if (fifo_level !== '0) begin n_fail++; $display("FAIL clr_level got %0d want 0", fifo_level); end
        if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", fifo_empty); end
        if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", fifo_overflow); end
        if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL clr_udf got %b want 0", fifo_underflow); end
        do_cycle(1'b1, w(32'hB7), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks += 2;
        if (data_from_fifo !== exp_dout) begin n_fail++; $display("FAIL clr_after_read got %h want %h", data_from_fifo, exp_dout); end
        if (fifo_level !== '0) begin n_fail++; $display("FAIL clr_after_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_random();
        int n_full_ev = 0;
        int n_empty_ev = 0;
        int prev;
        int start_writes;
        logic we, re, clr;
        start_writes = n_writes;
        for (int i = 0; i < 1000; i++) begin
            prev = q.size();
            if (((i / 20) % 2) == 0) begin
                we = ($urandom_range(99) < 80);
                re = ($urandom_range(99) < 30);
            end else begin
                we = ($urandom_range(99) < 30);
                re = ($urandom_range(99) < 80);
            end
            clr = ($urandom_range(255) == 0);
            do_cycle(we, rand_word(), re, clr);
            if (q.size() == DEPTH && prev != DEPTH) n_full_ev++;
            if (q.size() == 0 && prev != 0) n_empty_ev++;
            n_checks += 8;
            if (fifo_level !== LW'(q.size())) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d want %0d", i, fifo_level, q.size()); end
            if (data_from_fifo !== exp_dout) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", i, data_from_fifo, exp_dout); end
            if (fifo_empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %b", i, fifo_empty); end
            if (fifo_full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %b", i, fifo_full); end
            if (fifo_almost_full !== (q.size() >= AFULL_TH)) begin n_fail++; $display("FAIL rnd_afull cyc %0d got %b", i, fifo_almost_full); end
            if (fifo_almost_empty !== (q.size() <= AEMPTY_TH)) begin n_fail++; $display("FAIL rnd_aempty cyc %0d got %b", i, fifo_almost_empty); end
            if (fifo_overflow !== exp_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, fifo_overflow, exp_ovf); end
            if (fifo_underflow !== exp_udf) begin n_fail++; $display("FAIL rnd_udf cyc %0d got %b want %b", i, fifo_underflow, exp_udf); end
        end
        n_checks += 3;
        if (n_full_ev < 10) begin n_fail++; $display("FAIL rnd_full_events got %0d want >=10", n_full_ev); end
        if (n_empty_ev < 10) begin n_fail++; $display("FAIL rnd_empty_events got %0d want >=10", n_empty_ev); end
        if (n_writes - start_writes < 4 * DEPTH) begin n_fail++; $display("FAIL rnd_wrap writes %0d want >=%0d", n_writes - start_writes, 4 * DEPTH); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] nw;
        do_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, rand_word(), 1'b0, 1'b0);
        do_cycle(1'b1, w(32'h55), 1'b1, 1'b0);
        n_checks++;
        if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", fifo_level); end
        @(negedge clk_in);
        fifo_w_enable = 1'b1;
        fifo_r_enable = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks += 8;
        if (data_from_fifo !== '0) begin n_fail++; $display("FAIL mid_dout got %h want 0", data_from_fifo); end
        if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", fifo_empty); end
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_full got %b want 0", fifo_full); end
        if (fifo_almost_empty !== 1'b1) begin n_fail++; $display("FAIL mid_aempty got %b want 1", fifo_almost_empty); end
        if (fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL mid_afull got %b want 0", fifo_almost_full); end
        if (fifo_level !== '0) begin n_fail++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b want 0", fifo_overflow); end
        if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL mid_udf got %b want 0", fifo_underflow); end
        fifo_w_enable = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        nw = rand_word();
        do_cycle(1'b1, nw, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (data_from_fifo !== nw) begin n_fail++; $display("FAIL mid_fwft_new got %h want %h", data_from_fifo, nw); end
`endif
        do_cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (data_from_fifo !== nw) begin n_fail++; $display("FAIL mid_new_word got %h want %h", data_from_fifo, nw); end
`endif
        n_checks++;
        if (fifo_level !== '0) begin n_fail++; $display("FAIL mid_post_level got %0d want 0", fifo_level); end
    endtask

    initial begin
        n_writes = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_clear();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
